// File: rtl/pwr_seq_ctrl.sv
// Multi-domain power sequencer: switch enable, isolation, save/restore in timed order.
// Latency: outputs are registered, reflecting the state entered at the last clk edge.
// No backpressure: waits on sw_ack levels, staggers power-ups, times out into err.
module pwr_seq_ctrl #(
    parameter int NUM_DOM   = 2,
    parameter int CNT_W     = 8,
    parameter int T_SETTLE  = 4,
    parameter int T_SAVE    = 2,
    parameter int T_ISO     = 1,
    parameter int T_TIMEOUT = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_DOM-1:0] pwr_req,
    input  logic               sleep_mode,
    input  logic [NUM_DOM-1:0] sw_ack,
    input  logic               err_clr,
    output logic [NUM_DOM-1:0] sw_en,
    output logic [NUM_DOM-1:0] iso_en,
    output logic [NUM_DOM-1:0] save,
    output logic [NUM_DOM-1:0] restore,
    output logic [NUM_DOM-1:0] dom_on,
    output logic               busy,
    output logic [NUM_DOM-1:0] err
);

    typedef enum logic [2:0] {
        S_OFF, S_PUP, S_SETTLE, S_RESTORE, S_ON, S_ISO, S_SAVE, S_PDN
    } state_t;

    // Timed states load count-1 and leave when the counter reaches zero.
    localparam logic [CNT_W-1:0] L_SETTLE  = CNT_W'(T_SETTLE - 1);
    localparam logic [CNT_W-1:0] L_SAVE    = CNT_W'(T_SAVE - 1);
    localparam logic [CNT_W-1:0] L_ISO     = CNT_W'(T_ISO - 1);
    localparam logic [CNT_W-1:0] L_TIMEOUT = CNT_W'(T_TIMEOUT - 1);

    state_t             st      [NUM_DOM];
    state_t             st_nxt  [NUM_DOM];
    logic [CNT_W-1:0]   cnt     [NUM_DOM];
    logic [CNT_W-1:0]   cnt_nxt [NUM_DOM];

    logic [NUM_DOM-1:0] req_eff;
    logic [NUM_DOM-1:0] grant;
    logic [NUM_DOM-1:0] err_set;
    logic               pup_active;
    logic               granted_one;

    logic [NUM_DOM-1:0] sw_en_d;
    logic [NUM_DOM-1:0] iso_en_d;
    logic [NUM_DOM-1:0] save_d;
    logic [NUM_DOM-1:0] restore_d;
    logic [NUM_DOM-1:0] dom_on_d;
    logic [NUM_DOM-1:0] err_d;
    logic               busy_d;

    assign req_eff = pwr_req & ~{NUM_DOM{sleep_mode}};

    // Inrush limit: one domain in PUP/SETTLE at a time, lowest requesting index wins.
    always_comb begin
        pup_active  = 1'b0;
        granted_one = 1'b0;
        grant       = '0;
        for (int i = 0; i < NUM_DOM; i++) begin
            if (st[i] == S_PUP || st[i] == S_SETTLE) pup_active = 1'b1;
        end
        for (int i = 0; i < NUM_DOM; i++) begin
            if (!pup_active && !granted_one && st[i] == S_OFF && req_eff[i]) begin
                grant[i]    = 1'b1;
                granted_one = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_DOM; i++) begin
            st_nxt[i]  = st[i];
            cnt_nxt[i] = cnt[i];
            err_set[i] = 1'b0;
            case (st[i])
                S_OFF: begin
                    if (grant[i]) begin
                        st_nxt[i]  = S_PUP;
                        cnt_nxt[i] = '0;
                    end
                end
                S_PUP: begin
                    if (sw_ack[i]) begin
                        st_nxt[i]  = S_SETTLE;
                        cnt_nxt[i] = L_SETTLE;
                    end else if (cnt[i] == L_TIMEOUT) begin
                        st_nxt[i]  = S_OFF;
                        err_set[i] = 1'b1;
                    end else begin
                        cnt_nxt[i] = cnt[i] + CNT_W'(1);
                    end
                end
                S_SETTLE: begin
                    if (cnt[i] == '0) begin
                        st_nxt[i]  = S_RESTORE;
                        cnt_nxt[i] = L_SAVE;
                    end else begin
                        cnt_nxt[i] = cnt[i] - CNT_W'(1);
                    end
                end
                S_RESTORE: begin
                    if (cnt[i] == '0) st_nxt[i] = S_ON;
                    else              cnt_nxt[i] = cnt[i] - CNT_W'(1);
                end
                S_ON: begin
                    if (!req_eff[i]) begin
                        st_nxt[i]  = S_ISO;
                        cnt_nxt[i] = L_ISO;
                    end
                end
                S_ISO: begin
                    if (cnt[i] == '0) begin
                        st_nxt[i]  = S_SAVE;
                        cnt_nxt[i] = L_SAVE;
                    end else begin
                        cnt_nxt[i] = cnt[i] - CNT_W'(1);
                    end
                end
                S_SAVE: begin
                    if (cnt[i] == '0) begin
                        st_nxt[i]  = S_PDN;
                        cnt_nxt[i] = '0;
                    end else begin
                        cnt_nxt[i] = cnt[i] - CNT_W'(1);
                    end
                end
                S_PDN: begin
                    if (!sw_ack[i]) begin
                        st_nxt[i] = S_OFF;
                    end else if (cnt[i] == L_TIMEOUT) begin
                        st_nxt[i]  = S_OFF;
                        err_set[i] = 1'b1;
                    end else begin
                        cnt_nxt[i] = cnt[i] + CNT_W'(1);
                    end
                end
                default: st_nxt[i] = S_OFF;
            endcase
        end
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        busy_d = 1'b0;
        for (int i = 0; i < NUM_DOM; i++) begin
            sw_en_d[i]   = st_nxt[i] inside {S_PUP, S_SETTLE, S_RESTORE, S_ON, S_ISO, S_SAVE};
            iso_en_d[i]  = (st_nxt[i] != S_ON);
            save_d[i]    = (st_nxt[i] == S_SAVE);
            restore_d[i] = (st_nxt[i] == S_RESTORE);
            dom_on_d[i]  = (st_nxt[i] == S_ON);
            if (st_nxt[i] != S_OFF && st_nxt[i] != S_ON) busy_d = 1'b1;
        end
        err_d = err_set | (err & ~{NUM_DOM{err_clr}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DOM; i++) begin
                st[i]  <= S_OFF;
                cnt[i] <= '0;
            end
            sw_en   <= '0;
            iso_en  <= '1;
            save    <= '0;
            restore <= '0;
            dom_on  <= '0;
            busy    <= 1'b0;
            err     <= '0;
        end else begin
            for (int i = 0; i < NUM_DOM; i++) begin
                st[i]  <= st_nxt[i];
                cnt[i] <= cnt_nxt[i];
            end
            sw_en   <= sw_en_d;
            iso_en  <= iso_en_d;
            save    <= save_d;
            restore <= restore_d;
            dom_on  <= dom_on_d;
            busy    <= busy_d;
            err     <= err_d;
        end
    end

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// Bench for pwr_seq_ctrl: schedule-based reference model feeding a scoreboard queue.
// The model also plays the power switch, driving sw_ack after a chosen delay.
module tb_pwr_seq_ctrl;

    localparam int ND = 2;
    localparam int TT = 10;
    localparam int TS = 4;
    localparam int TSV = 2;
    localparam int TI = 1;

    localparam int K_OFF = 0, K_PUP = 1, K_SET = 2, K_RES = 3;
    localparam int K_ON = 4, K_ISO = 5, K_SAV = 6, K_PDN = 7;

    logic          clk;
    logic          rst_n;
    logic [ND-1:0] pwr_req;
    logic          sleep_mode;
    logic [ND-1:0] sw_ack;
    logic          err_clr;
    logic [ND-1:0] sw_en, iso_en, save, restore, dom_on, err;
    logic          busy;

    pwr_seq_ctrl #(
        .NUM_DOM(ND), .CNT_W(8), .T_SETTLE(TS), .T_SAVE(TSV), .T_ISO(TI), .T_TIMEOUT(TT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pwr_req(pwr_req), .sleep_mode(sleep_mode),
        .sw_ack(sw_ack), .err_clr(err_clr), .sw_en(sw_en), .iso_en(iso_en),
        .save(save), .restore(restore), .dom_on(dom_on), .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit done = 0;

    logic [6*ND:0] exp_q[$];

    // Each domain is either stable (OFF/ON) or working through a planned list of
    // (phase, duration) segments that ends in a stable state.
    int stable_k [ND];
    int plan_k   [ND][4];
    int plan_n   [ND][4];
    int plan_len [ND];
    int plan_pos [ND];
    int elapsed  [ND];
    int plan_end [ND];
    bit plan_err [ND];
    int dly      [ND];
    bit err_m    [ND];
    int d_force  [ND];
    int e_force  [ND];

    function automatic int kind_of(input int i);
        if (plan_pos[i] < plan_len[i]) return plan_k[i][plan_pos[i]];
        return stable_k[i];
    endfunction

    function automatic bit req_on(input int i);
        return pwr_req[i] & ~sleep_mode;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ND; i++) begin
            stable_k[i] = K_OFF;
            plan_len[i] = 0;
            plan_pos[i] = 0;
            elapsed[i]  = 0;
            err_m[i]    = 0;
        end
    endtask

    task automatic start_pup(input int i);
        int d;
        if (d_force[i] >= 0) d = d_force[i];
        else d = ($urandom_range(0, 7) == 0) ? 11 : int'($urandom_range(1, 6));
        dly[i] = d;
        plan_pos[i] = 0;
        elapsed[i] = 0;
        if (d <= TT) begin
            plan_k[i][0] = K_PUP; plan_n[i][0] = d;
            plan_k[i][1] = K_SET; plan_n[i][1] = TS;
            plan_k[i][2] = K_RES; plan_n[i][2] = TSV;
            plan_len[i] = 3; plan_end[i] = K_ON; plan_err[i] = 0;
        end else begin
            plan_k[i][0] = K_PUP; plan_n[i][0] = TT;
            plan_len[i] = 1; plan_end[i] = K_OFF; plan_err[i] = 1;
        end
    endtask

    task automatic start_pdn(input int i);
        int e;
        if (e_force[i] >= 0) e = e_force[i];
        else e = ($urandom_range(0, 7) == 0) ? 12 : int'($urandom_range(1, 5));
        dly[i] = e;
        plan_pos[i] = 0;
        elapsed[i] = 0;
        plan_k[i][0] = K_ISO; plan_n[i][0] = TI;
        plan_k[i][1] = K_SAV; plan_n[i][1] = TSV;
        plan_k[i][2] = K_PDN; plan_n[i][2] = (e <= TT) ? e : TT;
        plan_len[i] = 3; plan_end[i] = K_OFF; plan_err[i] = (e > TT);
    endtask

    task automatic model_step();
        int pre [ND];
        bit pup_busy = 0;
        bit granted = 0;
        bit set_e;
        for (int i = 0; i < ND; i++) begin
            pre[i] = kind_of(i);
            if (pre[i] == K_PUP || pre[i] == K_SET) pup_busy = 1;
        end
        for (int i = 0; i < ND; i++) begin
            set_e = 0;
            if (pre[i] == K_OFF) begin
                if (!pup_busy && !granted && req_on(i)) begin
                    start_pup(i);
                    granted = 1;
                end
            end else if (pre[i] == K_ON) begin
                if (!req_on(i)) start_pdn(i);
            end else begin
                elapsed[i]++;
                if (elapsed[i] == plan_n[i][plan_pos[i]]) begin
                    plan_pos[i]++;
                    elapsed[i] = 0;
                    if (plan_pos[i] == plan_len[i]) begin
                        stable_k[i] = plan_end[i];
                        plan_len[i] = 0;
                        plan_pos[i] = 0;
                        set_e = plan_err[i];
                    end
                end
            end
            if (set_e) err_m[i] = 1;
            else if (err_clr) err_m[i] = 0;
        end
    endtask

    // Switch model: rail comes up on cycle dly of PUP, goes down on cycle dly of PDN.
    task automatic drive_ack();
        int k, c;
        for (int i = 0; i < ND; i++) begin
            k = kind_of(i);
            c = elapsed[i] + 1;
            case (k)
                K_OFF:   sw_ack[i] = 1'b0;
                K_PUP:   sw_ack[i] = (c >= dly[i]);
                K_PDN:   sw_ack[i] = (c < dly[i]);
                default: sw_ack[i] = 1'b1;
            endcase
        end
    endtask

    function automatic logic [6*ND:0] expect_vec();
        logic [ND-1:0] s, iso, sv, rs, on, er;
        logic b;
        int k;
        b = 1'b0;
        for (int i = 0; i < ND; i++) begin
            k = kind_of(i);
            s[i]   = (k != K_OFF && k != K_PDN);
            iso[i] = (k != K_ON);
            sv[i]  = (k == K_SAV);
            rs[i]  = (k == K_RES);
            on[i]  = (k == K_ON);
            er[i]  = err_m[i];
            if (k != K_OFF && k != K_ON) b = 1'b1;
        end
        return {s, iso, sv, rs, on, er, b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rst_n) model_step();
        exp_q.push_back(expect_vec());
        drive_ack();
        cyc++;
    endtask

    // Asynchronous reset asserted mid-cycle; the pending expectation becomes the reset image.
    task automatic do_reset(input int n);
        rst_n = 1'b0;
        model_reset();
        if (exp_q.size() > 0) exp_q[exp_q.size()-1] = expect_vec();
        drive_ack();
        repeat (n) tick();
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        logic [6*ND:0] got, exp;
        while (!done) begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                got = {sw_en, iso_en, save, restore, dom_on, err, busy};
                total++;
                if (got !== exp) begin
                    bad++;
                    $display("FAIL outputs cyc=%0d got sw=%b iso=%b sav=%b res=%b on=%b err=%b busy=%b exp sw=%b iso=%b sav=%b res=%b on=%b err=%b busy=%b",
                             cyc, got[12:11], got[10:9], got[8:7], got[6:5], got[4:3], got[2:1], got[0],
                             exp[12:11], exp[10:9], exp[8:7], exp[6:5], exp[4:3], exp[2:1], exp[0]);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        bit found;
        rst_n = 1'b0;
        pwr_req = '0;
        sleep_mode = 1'b0;
        err_clr = 1'b0;
        d_force = '{-1, -1};
        e_force = '{-1, -1};
        for (int i = 0; i < ND; i++) dly[i] = 0;
        model_reset();
        drive_ack();
        repeat (3) tick();
        rst_n = 1'b1;

        // Single power-up with ack on PUP cycle 3, then power-down.
        d_force = '{3, -1};
        pwr_req = 2'b01;
        repeat (14) tick();
        e_force = '{2, -1};
        pwr_req = 2'b00;
        repeat (10) tick();

        // Simultaneous requests: stagger.
        d_force = '{2, 4};
        pwr_req = 2'b11;
        repeat (30) tick();
        e_force = '{1, 1};
        pwr_req = 2'b00;
        repeat (15) tick();

        // Switch timeout on domain 1, then clear err.
        d_force = '{-1, 99};
        pwr_req = 2'b10;
        repeat (12) tick();
        pwr_req = 2'b00;
        repeat (15) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        repeat (2) tick();

        // Sleep with both domains on.
        d_force = '{2, 2};
        e_force = '{3, 2};
        pwr_req = 2'b11;
        repeat (30) tick();
        sleep_mode = 1'b1;
        repeat (30) tick();
        sleep_mode = 1'b0;

        // Random traffic.
        d_force = '{-1, -1};
        e_force = '{-1, -1};
        repeat (3000) begin
            if ($urandom_range(0, 15) == 0) begin
                int idx = int'($urandom_range(0, ND - 1));
                pwr_req[idx] = ~pwr_req[idx];
            end
            if ($urandom_range(0, 63) == 0) sleep_mode = ~sleep_mode;
            err_clr = ($urandom_range(0, 31) == 0);
            tick();
        end
        err_clr = 1'b0;
        sleep_mode = 1'b0;

        // Reset asserted while domain 0 is in SAVE.
        pwr_req = 2'b01;
        d_force = '{1, -1};
        e_force = '{3, 3};
        found = 0;
        for (int n = 0; n < 300 && !found; n++) begin
            if (kind_of(0) == K_ON) pwr_req = 2'b00;
            if (kind_of(0) == K_OFF && kind_of(1) == K_OFF) pwr_req = 2'b01;
            tick();
            if (kind_of(0) == K_SAV) found = 1;
        end
        if (!found) begin
            total++;
            bad++;
            $display("FAIL reach_save got not reached exp SAVE within 300 cycles");
        end
        do_reset(2);
        repeat (5) tick();

        repeat (2) @(posedge clk);
        done = 1;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
